// File: rtl/updown_mod_counter.sv
// Universal up/down modulo counter: runtime terminal value, wrap or saturate
// at the boundary, and a sticky overflow flag.
module updown_mod_counter #(
  parameter int WIDTH       = 4,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             count,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat,
  output logic [WIDTH-1:0] a_count,
  output logic             c_out,
  output logic             zero,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] RST = RESET_VALUE[WIDTH-1:0];

  logic             bnd;
  logic             step;
  logic [WIDTH-1:0] nxt;

  // Up boundary uses >= so a loaded value above limit still terminates.
  assign bnd   = up ? (a_count >= limit) : (a_count == '0);
  assign step  = count & ~load & ~clear;
  assign c_out = step & bnd;
  assign zero  = (a_count == '0);

  always_comb begin
    nxt = a_count;
    if (up) begin
      if (!bnd)     nxt = a_count + 1'b1;
      else if (sat) nxt = limit;
      else          nxt = '0;
    end else begin
      if (!bnd)     nxt = a_count - 1'b1;
      else if (sat) nxt = '0;
      else          nxt = limit;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      a_count <= RST;
      ovf     <= 1'b0;
    end else if (load) begin
      a_count <= din;
      ovf     <= 1'b0;
    end else if (count) begin
      a_count <= nxt;
      if (bnd) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed plan plus random traffic for updown_mod_counter, compared against
// an integer-arithmetic reference of the counting rules.
module tb_updown_mod_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clear, load, count, up, sat;
  logic [W-1:0] din, limit, a_count;
  logic         c_out, zero, ovf;

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;
  int m_ovf  = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(W), .RESET_VALUE(0)) dut (
    .clk(clk), .clear(clear), .load(load), .din(din), .count(count),
    .up(up), .limit(limit), .sat(sat),
    .a_count(a_count), .c_out(c_out), .zero(zero), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model on the edge.
  task automatic cyc(input bit c_clr, input bit c_ld, input int c_din, input bit c_cnt,
                     input bit c_up, input int c_lim, input bit c_sat);
    bit m_bnd;
    clear = c_clr; load = c_ld; din = c_din[W-1:0]; count = c_cnt;
    up = c_up; limit = c_lim[W-1:0]; sat = c_sat;
    m_bnd = c_up ? (m_cnt >= c_lim) : (m_cnt == 0);
    @(negedge clk);
    chk("a_count", {28'd0, a_count}, m_cnt);
    chk("ovf",     {31'd0, ovf},     m_ovf);
    chk("zero",    {31'd0, zero},    (m_cnt == 0));
    chk("c_out",   {31'd0, c_out},   (c_cnt && !c_ld && !c_clr && m_bnd));
    @(posedge clk);
    if (c_clr) begin
      m_cnt = 0; m_ovf = 0;
    end else if (c_ld) begin
      m_cnt = c_din; m_ovf = 0;
    end else if (c_cnt) begin
      if (m_bnd) m_ovf = 1;
      if (c_up) m_cnt = m_bnd ? (c_sat ? c_lim : 0) : m_cnt + 1;
      else      m_cnt = m_bnd ? (c_sat ? 0 : c_lim) : m_cnt - 1;
    end
    #1;
  endtask

  initial begin
    clear = 1'b1; load = 1'b0; din = '0; count = 1'b0; up = 1'b1; limit = '0; sat = 1'b0;
    @(posedge clk); #1;

    // Reset dominates load and count
    cyc(1, 1, 7, 1, 1, 9, 0);
    cyc(1, 1, 7, 1, 1, 9, 0);
    chk("reset_cnt", {28'd0, a_count}, 0);

    // Up wrap at limit 9
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 1, 9, 0);
    chk("upwrap_0", {28'd0, a_count}, 0);
    chk("upwrap_ovf", {31'd0, ovf}, 1);
    cyc(0, 0, 0, 1, 1, 9, 0);
    cyc(0, 0, 0, 1, 1, 9, 0);

    // Down wrap reloads limit
    cyc(0, 1, 2, 0, 0, 9, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 9, 0);
    chk("downwrap_9", {28'd0, a_count}, 9);
    chk("downwrap_ovf", {31'd0, ovf}, 1);
    cyc(0, 0, 0, 1, 0, 9, 0);

    // Saturate up then count down
    cyc(0, 1, 13, 0, 1, 15, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 15, 1);
    chk("sat_hold_15", {28'd0, a_count}, 15);
    cyc(0, 0, 0, 1, 0, 15, 1);
    cyc(0, 0, 0, 1, 0, 15, 1);
    chk("sat_down_13", {28'd0, a_count}, 13);

    // Load beats count and clears ovf
    cyc(0, 1, 9, 0, 1, 9, 1);
    cyc(0, 0, 0, 1, 1, 9, 1);
    chk("pre_load_ovf", {31'd0, ovf}, 1);
    cyc(0, 1, 3, 1, 1, 9, 1);
    chk("load_prio", {28'd0, a_count}, 3);
    chk("load_ovf_clr", {31'd0, ovf}, 0);

    // Values above limit
    cyc(0, 1, 12, 0, 1, 9, 0);
    cyc(0, 0, 0, 1, 1, 9, 0);
    chk("above_wrap", {28'd0, a_count}, 0);
    cyc(0, 1, 12, 0, 0, 9, 0);
    cyc(0, 0, 0, 1, 0, 9, 0);
    chk("above_down", {28'd0, a_count}, 11);
    cyc(0, 1, 12, 0, 1, 9, 1);
    cyc(0, 0, 0, 1, 1, 9, 1);
    chk("above_sat", {28'd0, a_count}, 9);

    // limit 0, up, wrap: holds 0
    cyc(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 0, 0);
    chk("lim0_hold", {28'd0, a_count}, 0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0), $urandom_range(0, 15),
          ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
          ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 15), $urandom_range(0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
